// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 target that decodes 16-bit write frames into the five
// 8-bit PWM control registers. Raw pads are synchronized into the clk domain.
// Optional readback path enabled by defining SPI_READBACK_EN.
module spi_reg_bank #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned NREG    = MAX_ADDR + 1;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    OVERRUN   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_prev_q;
  logic                   ncs_prev_q;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [FRAME_W-1:0]     shift_q;
  logic [FRAME_W-1:0]     shift_d;
  logic [DATA_W-1:0]      regs_q [NREG];
  logic                   wr_strobe_q;

  logic                   sclk_s;
  logic                   copi_s;
  logic                   ncs_s;
  logic                   sclk_rise;
  logic                   ncs_rise;
  logic                   ncs_fall;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   commit;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  assign shift_d = {shift_q[FRAME_W-2:0], copi_s};
  assign wr_addr = shift_q[FRAME_W-2 -: ADDR_W];
  assign wr_data = shift_q[DATA_W-1:0];

  // A frame commits only when it closed cleanly with exactly FRAME_W bits of a write.
  assign commit = ncs_rise && (state_q == SHIFT) && (cnt_q == CNT_W'(FRAME_W)) &&
                  shift_q[FRAME_W-1] && (wr_addr <= ADDR_W'(MAX_ADDR));

  // Input synchronizers, edge-detect history, frame FSM and register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      wr_strobe_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      wr_strobe_q <= commit;

      case (state_q)
        WAIT_IDLE: if (ncs_s) state_q <= IDLE;
        IDLE: begin
          if (ncs_fall) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end
        SHIFT: begin
          if (ncs_rise) begin
            state_q <= IDLE;
          end else if (sclk_rise) begin
            if (cnt_q == CNT_W'(FRAME_W)) begin
              state_q <= OVERRUN;
            end else begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
        end
        OVERRUN: if (ncs_rise) state_q <= IDLE;
        default: state_q <= WAIT_IDLE;
      endcase

      for (int unsigned i = 0; i < NREG; i++) begin
        if (commit && (wr_addr == ADDR_W'(i))) regs_q[i] <= wr_data;
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_strobe       = wr_strobe_q;

`ifdef SPI_READBACK_EN
  localparam int unsigned HDR_W = 1 + ADDR_W;

  logic              sclk_fall;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tx_q;

  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // Header is complete on the current rise: include the bit being sampled now.
  assign rd_addr   = {shift_q[ADDR_W-2:0], copi_s};

  // Readback mux; out-of-range addresses return register 0.
  always_comb begin
    rd_data = regs_q[0];
    for (int unsigned i = 0; i < NREG; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i];
    end
  end

  // Tx shifter: load on the last header rise of a read; bit7 stays put across the
  // following fall so the host samples it on the next rise, then shift on later falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= '0;
    end else if ((state_q != SHIFT) || ncs_rise) begin
      tx_q <= '0;
    end else if (sclk_rise && (cnt_q == CNT_W'(HDR_W - 1)) && !shift_q[HDR_W-2]) begin
      tx_q <= rd_data;
    end else if (sclk_fall && (cnt_q > CNT_W'(HDR_W))) begin
      tx_q <= {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  assign cipo = tx_q[DATA_W-1];
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios followed by random frames
// scored against a register-array model of the frame rules.
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       cipo;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;

  int total = 0;
  int bad   = 0;
  int strobes = 0;

  logic [7:0] model [5];

  spi_reg_bank dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .cipo            (cipo),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe === 1'b1) strobes++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic c);
    copi = b;
    wait_clk(6);
    c = cipo;
    sclk = 1'b1;
    wait_clk(6);
    sclk = 1'b0;
  endtask

  // Sends the low n bits of w, MSB first; returns cipo seen before rises 9..16.
  task automatic spi_frame(input logic [31:0] w, input int n, output logic [7:0] rd);
    logic c;
    rd = 8'h00;
    ncs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < n; i++) begin
      send_bit(w[n-1-i], c);
      if (i >= 8 && i < 16) rd[15-i] = c;
    end
    wait_clk(6);
    ncs = 1'b1;
    wait_clk(8);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".r0"}, 32'(en_reg_out_7_0),  32'(model[0]));
    check({tag, ".r1"}, 32'(en_reg_out_15_8), 32'(model[1]));
    check({tag, ".r2"}, 32'(en_reg_pwm_7_0),  32'(model[2]));
    check({tag, ".r3"}, 32'(en_reg_pwm_15_8), 32'(model[3]));
    check({tag, ".r4"}, 32'(pwm_duty_cycle),  32'(model[4]));
  endtask

  // Model: only a complete 16-bit write frame to an implemented address takes effect.
  task automatic model_frame(input logic [15:0] f, input int n, output int wrote);
    int a;
    a = int'(f[14:8]);
    wrote = 0;
    if (n == 16 && f[15] && a <= 4) begin
      model[a] = f[7:0];
      wrote = 1;
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] addr);
    int a;
    a = int'(addr);
    return (a <= 4) ? model[a] : model[0];
  endfunction

  task automatic do_frame(input string tag, input logic [15:0] f, input int n, input logic extra);
    logic [31:0] w;
    logic [7:0]  rd;
    logic [7:0]  exp_rd;
    int          s0;
    int          wrote;
    if (n == 16)      w = 32'(f);
    else if (n == 17) w = {15'd0, f, extra};
    else              w = 32'(f >> (16 - n));
    exp_rd = 8'h00;
`ifdef SPI_READBACK_EN
    if (!f[15] && n >= 9) begin
      exp_rd = model_read(f[14:8]);
      if (n < 16) exp_rd = exp_rd & ~(8'hFF >> (n - 8));
    end
`endif
    s0 = strobes;
    spi_frame(w, n, rd);
    model_frame(f, n, wrote);
    check_regs(tag);
    check({tag, ".strobe"}, 32'(strobes - s0), 32'(wrote));
    check({tag, ".rd"}, 32'(rd), 32'(exp_rd));
    check({tag, ".cipo_idle"}, 32'(cipo), 32'd0);
  endtask

  initial begin
    logic [15:0] f;
    logic [7:0]  rd;
    logic        c;
    int          n;
    int          s0;

    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    check_regs("reset");
    check("reset.strobe", 32'(wr_strobe), 32'd0);
    check("reset.cipo", 32'(cipo), 32'd0);
    wait_clk(4);

    do_frame("t1", 16'h80F0, 16, 1'b0);
    do_frame("t2a", 16'h8480, 16, 1'b0);
    do_frame("t2b", 16'h83AA, 16, 1'b0);
    do_frame("t3short", 16'h8011, 15, 1'b0);
    do_frame("t3long", 16'h8022, 17, 1'b1);
    do_frame("t4addr5", 16'h8555, 16, 1'b0);
    do_frame("t4read", 16'h0012, 16, 1'b0);

    // Empty frame: chip-select pulse with no clocks.
    s0 = strobes;
    ncs = 1'b0; wait_clk(8); ncs = 1'b1; wait_clk(8);
    check_regs("empty");
    check("empty.strobe", 32'(strobes - s0), 32'd0);

    // Reset in the middle of a frame, released with chip select still low.
    s0 = strobes;
    f = 16'h81FF;
    ncs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 8; i++) send_bit(f[15-i], c);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    for (int i = 8; i < 16; i++) send_bit(f[15-i], c);
    wait_clk(6);
    ncs = 1'b1;
    wait_clk(8);
    check_regs("t5cut");
    check("t5cut.strobe", 32'(strobes - s0), 32'd0);
    do_frame("t5full", 16'h81FF, 16, 1'b0);

    do_frame("t6wr", 16'h845A, 16, 1'b0);
    do_frame("t6rd", 16'h0400, 16, 1'b0);

    // Random frames: mixed lengths, directions and addresses.
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 4))
        0:       n = 15;
        1:       n = 17;
        default: n = 16;
      endcase
      f[15]   = 1'($urandom_range(0, 1));
      f[14:8] = 7'($urandom_range(0, 6));
      f[7:0]  = 8'($urandom);
      do_frame($sformatf("rnd%0d", k), f, n, 1'($urandom_range(0, 1)));
    end

    rd = 8'h00;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
